// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants, kind codes and encoder state type.
// Common to the control decoder and the instruction encoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    K_RTYPE   = 3'd0,
    K_ADDI    = 3'd1,
    K_ANDI    = 3'd2,
    K_BEQ     = 3'd3,
    K_JAL     = 3'd4,
    K_LW      = 3'd5,
    K_SW      = 3'd6,
    K_ILLEGAL = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2,
    S_DONE = 2'd3
  } encState_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packing: kind plus fields to a 32-bit MIPS word.
// Fields a kind does not use never reach the word.
module instr_pack
  import mips_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  kind_e k;
  assign k = kind_e'(kind);

  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    unique case (k)
      K_RTYPE: word = {OP_RTYPE, rs, rt, rd, 5'b0, funct};
      K_ADDI:  word = {OP_ADDI, rs, rt, imm};
      K_ANDI:  word = {OP_ANDI, rs, rt, imm};
      K_BEQ:   word = {OP_BEQ, rs, rt, imm};
      K_JAL:   word = {OP_JAL, target};
      K_LW:    word = {OP_LW, rs, rt, imm};
      K_SW:    word = {OP_SW, rs, rt, imm};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes instruction requests and streams them into
// instruction memory, one word per cycle, starting at base_addr.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_MAX  = '1;

  encState_e         state;
  logic [ADDR_W-1:0] wrAddr;
  logic [31:0]       packWord;
  logic              illegal;
  logic              accept;
  logic              legalAcc;

  instr_pack uPack (
    .kind    (kind),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .funct   (funct),
    .imm     (imm),
    .target  (target),
    .word    (packWord),
    .illegal (illegal)
  );

  assign in_ready = (state == S_RUN);
  assign busy     = (state == S_RUN);
  assign accept   = in_valid && in_ready;
  assign legalAcc = accept && !illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wrAddr     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      // An accepted word is written even if start arrives alongside it.
      if (legalAcc) begin
        imem_we    <= 1'b1;
        imem_addr  <= wrAddr;
        imem_wdata <= packWord;
      end
      if (start) begin
        state  <= S_RUN;
        wrAddr <= base_addr;
        count  <= '0;
        err    <= 1'b0;
        full   <= 1'b0;
      end else if (state == S_RUN) begin
        if (accept && illegal) err <= 1'b1;
        if (legalAcc) begin
          wrAddr <= wrAddr + ADDR_ONE;
          if (count != CNT_MAX) count <= count + CNT_ONE;
        end
        if (legalAcc && (&wrAddr)) begin
          full  <= 1'b1;
          state <= S_FULL;
        end else if (finish) begin
          state <= S_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table plus
// hand sequences for illegal, full, finish, restart and reset.
module tb_instr_encoder;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          finish;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    kind;
  logic [4:0]    rs, rt, rd;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;
  logic          busy;

  int vecCnt = 0;
  int errCnt = 0;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .kind       (kind),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .funct      (funct),
    .imm        (imm),
    .target     (target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] k, input logic [4:0] s,
                     input logic [4:0] t, input logic [4:0] d,
                     input logic [5:0] f, input logic [15:0] i,
                     input logic [25:0] tg);
    in_valid = 1'b1;
    kind = k; rs = s; rt = t; rd = d;
    funct = f; imm = i; target = tg;
  endtask

  initial begin
    // Unused fields carry junk so any leak shows in the word.
    tbl[0] = '{3'd0, 5'd9,  5'd10, 5'd8,  6'h20, 16'hFFFF, 26'h3FFFFFF, 32'h012A4020};
    tbl[1] = '{3'd4, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000010, 32'h0C000010};
    tbl[2] = '{3'd2, 5'd1,  5'd2,  5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h3022FFFF};
    tbl[3] = '{3'd3, 5'd3,  5'd4,  5'd7,  6'h11, 16'h8000, 26'h1234567, 32'h10648000};
    tbl[4] = '{3'd5, 5'd29, 5'd8,  5'd1,  6'h01, 16'h0010, 26'h0ABCDEF, 32'h8FA80010};
    tbl[5] = '{3'd6, 5'd29, 5'd31, 5'd5,  6'h2A, 16'h0004, 26'h3FFFFFF, 32'hAFBF0004};
    tbl[6] = '{3'd0, 5'd17, 5'd18, 5'd16, 6'h2A, 16'hFFFF, 26'h3FFFFFF, 32'h0232802A};

    reset = 1'b1; start = 1'b0; base_addr = '0; finish = 1'b0;
    in_valid = 1'b0; kind = '0; rs = '0; rt = '0; rd = '0;
    funct = '0; imm = '0; target = '0;
    tick(); tick();
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_flags", {full, err, busy, in_ready}, 0);

    reset = 1'b0;
    in_valid = 1'b1;
    tick();
    chk("idle_ready", in_ready, 0);
    chk("idle_we", imem_we, 0);
    in_valid = 1'b0;

    start = 1'b1; base_addr = 8'h00;
    tick();
    start = 1'b0;
    chk("start_busy", {busy, in_ready}, 2'b11);
    chk("start_count", count, 0);

    req(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0);
    tick();
    chk("addi_we", imem_we, 1);
    chk("addi_addr", imem_addr, 8'h00);
    chk("addi_wdata", imem_wdata, 32'h20080005);
    chk("addi_count", count, 1);

    for (int i = 0; i < 7; i++) begin
      req(tbl[i].kind, tbl[i].rs, tbl[i].rt, tbl[i].rd,
          tbl[i].funct, tbl[i].imm, tbl[i].target);
      tick();
      chk($sformatf("tbl%0d_we", i), imem_we, 1);
      chk($sformatf("tbl%0d_addr", i), imem_addr, i + 1);
      chk($sformatf("tbl%0d_wdata", i), imem_wdata, tbl[i].exp);
      chk($sformatf("tbl%0d_count", i), count, i + 2);
    end

    in_valid = 1'b0;
    tick();
    chk("idle_we_pulse", imem_we, 0);

    req(3'd7, 5'd1, 5'd2, 5'd3, 6'd4, 16'd5, 26'd6);
    tick();
    in_valid = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_we", imem_we, 0);
    chk("ill_count", count, 8);
    chk("ill_ready", in_ready, 1);

    req(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd7, 26'd0);
    tick();
    in_valid = 1'b0;
    chk("postill_addr", imem_addr, 8'h08);
    chk("postill_count", count, 9);
    chk("postill_err", err, 1);

    start = 1'b1; base_addr = 8'hFE;
    tick();
    start = 1'b0;
    chk("full_start_err", err, 0);
    chk("full_start_count", count, 0);
    req(3'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0);
    tick();
    chk("full_w1_addr", imem_addr, 8'hFE);
    chk("full_w1_state", {full, in_ready}, 2'b01);
    tick();
    in_valid = 1'b0;
    chk("full_w2_we", imem_we, 1);
    chk("full_w2_addr", imem_addr, 8'hFF);
    chk("full_w2_state", {full, in_ready, busy}, 3'b100);
    chk("full_w2_count", count, 2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("full_hold_we", imem_we, 0);
    chk("full_hold_ready", in_ready, 0);
    start = 1'b1; base_addr = 8'h20;
    tick();
    start = 1'b0;
    chk("full_restart", {full, in_ready}, 2'b01);

    req(3'd6, 5'd29, 5'd31, 5'd0, 6'd0, 16'd4, 26'd0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("fin_we", imem_we, 1);
    chk("fin_addr", imem_addr, 8'h20);
    chk("fin_wdata", imem_wdata, 32'hAFBF0004);
    chk("fin_state", {in_ready, busy}, 2'b00);
    tick();
    in_valid = 1'b0;
    chk("done_we", imem_we, 0);
    chk("done_count", count, 1);

    start = 1'b1; finish = 1'b1; base_addr = 8'h30;
    tick();
    start = 1'b0; finish = 1'b0;
    chk("startfin_busy", {busy, in_ready}, 2'b11);

    req(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000055);
    tick();
    in_valid = 1'b0;
    start = 1'b1; base_addr = 8'h40;
    chk("pend_addr", imem_addr, 8'h30);
    tick();
    start = 1'b0;
    chk("pend_we_drop", imem_we, 0);
    req(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd9, 26'd0);
    tick();
    in_valid = 1'b0;
    chk("restart_addr", imem_addr, 8'h40);
    chk("restart_count", count, 1);

    req(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd3, 26'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("mrst_we", imem_we, 0);
    chk("mrst_addr", imem_addr, 0);
    chk("mrst_wdata", imem_wdata, 0);
    chk("mrst_count", count, 0);
    chk("mrst_flags", {full, err, busy, in_ready}, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("mrst_wait_ready", in_ready, 0);
    chk("mrst_wait_we", imem_we, 0);
    in_valid = 1'b0;
    start = 1'b1; base_addr = 8'h05;
    tick();
    start = 1'b0;
    req(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0);
    tick();
    in_valid = 1'b0;
    chk("mrst_resume_addr", imem_addr, 8'h05);
    chk("mrst_resume_wdata", imem_wdata, 32'h20080005);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDR_W, default 8, width of the instruction-memory word address.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  pulse; loads base_addr, clears the count and error, and enters RUN.
REQ-005 base_addr  input  ADDR_W  first word address of the program.
REQ-006 finish  input  1  pulse; ends the program load.
REQ-007 in_valid  input  1  an instruction request is present.
REQ-008 in_ready  output  1  the encoder accepts a request this cycle.
REQ-009 kind  input  3  operation: 0 R-type, 1 addi, 2 andi, 3 beq, 4 jal, 5 lw, 6 sw, 7 illegal.
REQ-010 rs, rt, rd  input  5 each  register fields.
REQ-011 funct  input  6  R-type function field.
REQ-012 imm  input  16  I-type immediate.
REQ-013 target  input  26  jal target field.
REQ-014 imem_we  output  1  instruction-memory write strobe.
REQ-015 imem_addr  output  ADDR_W  write word address.
REQ-016 imem_wdata  output  32  encoded instruction.
REQ-017 count  output  ADDR_W+1  number of words written since start.
REQ-018 full  output  1  last address (all ones) has been written.
REQ-019 err  output  1  sticky flag; an illegal kind was accepted.
REQ-020 busy  output  1  high in state RUN.

Function
REQ-021 States and exits:
- IDLE: exits only on start.
- RUN: finish -> DONE; write to the all-ones address -> FULL.
- FULL: exits only on start.
- DONE: exits only on start.
REQ-022 start is honoured in every state, and start wins over a simultaneous finish.
REQ-023 in_ready = (state==RUN); a request is accepted on a cycle where in_valid && in_ready.
REQ-024 Latency is 1: an accept in cycle N drives imem_we=1 in cycle N+1, with registered imem_addr and imem_wdata.
REQ-025 Throughput is one word per cycle, with no back-pressure from memory.
REQ-026 Encodings:
- R-type: {6'h00, rs, rt, rd, 5'b0, funct}.
- I-type: {op, rs, rt, imm}, with op addi 6'h08, andi 6'h0C, beq 6'h04, lw 6'h23, sw 6'h2B.
- jal: {6'h03, target}.
REQ-027 Unused fields are ignored for each kind.
REQ-028 On an illegal kind, the request is accepted, err is set, no write occurs, and neither the address nor count advances.
REQ-029 The write address starts at base_addr and increments by 1 after each legal write.
REQ-030 count increments per legal write and never wraps.
REQ-031 A legal write to the all-ones address sets full, enters FULL and deasserts in_ready in the same cycle as that write.
REQ-032 An accept in the same cycle as finish still writes in the next cycle; after that, in_ready=0.
REQ-033 A write pending from the cycle before start completes at its old address; start then loads base_addr for the next accept.
REQ-034 imem_we is never high for more than one cycle per accept.

Reset
REQ-035 Asserting reset at any time forces state IDLE and all outputs 0, including imem_we, imem_addr, imem_wdata, count, full, err and busy.
REQ-036 A write pending at reset assertion is dropped.
REQ-037 After reset deasserts, the block waits for start.

Structure
REQ-038 Opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_BEQ, OP_JAL, OP_LW, OP_SW) and the kind codes live in shared package mips_pkg, common with the control decoder.
REQ-039 The combinational field packing is sub-module instr_pack, which maps kind and fields to a 32-bit word plus an illegal flag.
REQ-040 The FSM, address/count registers and output register reside in instr_encoder.

Verification
REQ-041 addi: start with base_addr=0x00, then accept kind=1, rs=0, rt=8, imm=5 -> next cycle imem_we=1, addr=0x00, wdata=0x20080005, count=1.
REQ-042 R-type: accept kind=0, rs=9, rt=10, rd=8, funct=0x20, then jal target=0x10, back-to-back -> wdata 0x012A4020 at addr n, then 0x0C000010 at n+1.
REQ-043 sw: accept kind=6, rs=29, rt=31, imm=4 -> 0xAFBF0004; then kind=7 -> err=1, no imem_we, addr and count unchanged.
REQ-044 Full: base_addr=0xFE with two legal accepts -> writes at 0xFE and 0xFF; full=1 and in_ready=0 after the second accept; a further start restores in_ready=1.
REQ-045 Finish and restart: finish with in_valid high in the same cycle -> that word is written, then DONE with in_ready=0; start and finish together -> RUN.
REQ-046 Reset mid-operation: reset asserted the cycle after an accept -> imem_we=0 immediately, all outputs 0, in_ready=0 until start.
